// File: rtl/uart_rx_if.sv
// UART receive front-end signal bundle.
// master drives the line and configuration; slave is the controller.
interface uart_rx_if #(
   parameter int PRESC_W = 6
);
   logic               RX_IN;
   logic [PRESC_W-1:0] Prescale;
   logic               PAR_EN;
   logic               PAR_TYP;
   logic               sampled_bit;
   logic               deser_en;
   logic               data_valid;
   logic               par_err;
   logic               stp_err;

   modport master (
      output RX_IN, Prescale, PAR_EN, PAR_TYP,
      input  sampled_bit, deser_en, data_valid, par_err, stp_err
   );

   modport slave (
      input  RX_IN, Prescale, PAR_EN, PAR_TYP,
      output sampled_bit, deser_en, data_valid, par_err, stp_err
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampling, 3-sample majority vote,
// frame sequencing and start/parity/stop checking.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_rx_if.slave rx
);
   localparam int BCW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;

   state_t             state_q, state_d;
   logic [PRESC_W-1:0] p_q, edge_cnt;
   logic [PRESC_W-1:0] mid, last, pre;
   logic [BCW-1:0]     bit_cnt;
   logic [2:0]         smp;
   logic               vote, wrap, at_pre, par_mis;
   logic               sampled_q, acc, fail;
   logic               de_q, dv_q, pe_q, se_q;
   logic               de_d, dv_d, pe_d, se_d;

   assign mid    = p_q >> 1;
   assign last   = p_q - PRESC_W'(1);
   assign pre    = p_q - PRESC_W'(2);
   assign wrap   = (state_q != IDLE) && (edge_cnt == last);
   assign at_pre = (state_q != IDLE) && (edge_cnt == pre);
   assign vote   = (smp[0] & smp[1]) | (smp[0] & smp[2])
                 | (smp[1] & smp[2]);
   assign par_mis = vote ^ acc ^ rx.PAR_TYP;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!rx.RX_IN) state_d = START;
         START:   if (wrap) state_d = sampled_q ? IDLE : DATA;
         DATA:    if (wrap && bit_cnt == BCW'(DATA_WIDTH - 1))
                     state_d = rx.PAR_EN ? PARITY : STOP;
         PARITY:  if (wrap) state_d = STOP;
         STOP:    if (wrap) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Decisions are taken one cycle early from the live vote so the
   // registered pulses line up with the edge_cnt == P-1 cycle.
   always_comb begin
      de_d = at_pre && (state_q == DATA);
      pe_d = at_pre && (state_q == PARITY) && par_mis;
      se_d = at_pre && (state_q == STOP) && !vote;
      dv_d = at_pre && (state_q == STOP) && vote && !fail;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q       <= '0;
         edge_cnt  <= '0;
         bit_cnt   <= '0;
         smp       <= '0;
         sampled_q <= 1'b1;
         acc       <= 1'b0;
         fail      <= 1'b0;
         de_q      <= 1'b0;
         dv_q      <= 1'b0;
         pe_q      <= 1'b0;
         se_q      <= 1'b0;
      end else begin
         de_q <= de_d;
         dv_q <= dv_d;
         pe_q <= pe_d;
         se_q <= se_d;
         if (state_q == IDLE) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            acc      <= 1'b0;
            fail     <= 1'b0;
            if (!rx.RX_IN) p_q <= rx.Prescale;
         end else begin
            edge_cnt <= wrap ? '0 : edge_cnt + PRESC_W'(1);
            if (edge_cnt == mid - PRESC_W'(1)) smp[0] <= rx.RX_IN;
            if (edge_cnt == mid)               smp[1] <= rx.RX_IN;
            if (edge_cnt == mid + PRESC_W'(1)) smp[2] <= rx.RX_IN;
            if (edge_cnt == mid + PRESC_W'(2)) sampled_q <= vote;
            if (wrap && state_q == DATA) begin
               bit_cnt <= bit_cnt + BCW'(1);
               acc     <= acc ^ sampled_q;
            end
            if (pe_d) fail <= 1'b1;
         end
      end
   end

   assign rx.sampled_bit = sampled_q;
   assign rx.deser_en    = de_q;
   assign rx.data_valid  = dv_q;
   assign rx.par_err     = pe_q;
   assign rx.stp_err     = se_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with an event scoreboard.
// Pulses are popped from the queue and checked for kind, cycle and bit.
module tb_uart_rx_ctrl;
   localparam int PW = 6;
   localparam logic [3:0] DE = 4'b0001;
   localparam logic [3:0] SE = 4'b0010;
   localparam logic [3:0] PE = 4'b0100;
   localparam logic [3:0] DV = 4'b1000;

   typedef struct {
      logic [3:0] kind;
      int         cyc;
      logic       bitv;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   passed = 0;
   int   fails = 0;
   ev_t  sbq[$];
   ev_t  ev;
   logic [3:0] obs;
   logic [7:0] deser = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_if #(.PRESC_W(PW)) bus ();

   uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_W(PW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .rx   (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      checks++;
      assert (o === e) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic ev_t mk(input logic [3:0] k, input int c,
                              input logic b);
      ev_t r;
      r.kind = k;
      r.cyc  = c;
      r.bitv = b;
      return r;
   endfunction

   // Every observed pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      obs = {bus.data_valid, bus.par_err, bus.stp_err, bus.deser_en};
      if (rst_n && obs != 4'b0) begin
         if (bus.deser_en) deser = {bus.sampled_bit, deser[7:1]};
         if (sbq.size() == 0) chk("spurious_pulse", 32'(obs), 32'd0);
         else begin
            ev = sbq.pop_front();
            chk("evt_kind", 32'(obs), 32'(ev.kind));
            chk("evt_cyc", cyc, ev.cyc);
            if (ev.kind == DE)
               chk("evt_bit", 32'(bus.sampled_bit), 32'(ev.bitv));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.RX_IN = 1'b1;
      end
   endtask

   // lead: cycles between the first low level and the DUT's t0 edge.
   // gbit: frame bit that gets a one-cycle inversion on the middle sample.
   task automatic send(input logic [7:0] d, input int p, input bit pe,
                       input bit pt, input bit bad_par, input bit stop,
                       input int lead, input bit chg, input int gbit);
      logic b[11];
      int   n;
      int   e0;
      logic par;
      par = (^d) ^ pt;
      if (bad_par) par = ~par;
      b[0] = 1'b0;
      for (int i = 0; i < 8; i++) b[i+1] = d[i];
      n = 9;
      if (pe) begin
         b[n] = par;
         n++;
      end
      b[n] = stop;
      n++;
      @(negedge clk);
      e0 = cyc + 1 + lead;
      for (int i = 0; i < 8; i++)
         sbq.push_back(mk(DE, e0 + (i + 2) * p - 1, d[i]));
      if (pe && bad_par) sbq.push_back(mk(PE, e0 + 10 * p - 1, 1'b0));
      if (!stop) sbq.push_back(mk(SE, e0 + n * p - 1, 1'b0));
      else if (!(pe && bad_par))
         sbq.push_back(mk(DV, e0 + n * p - 1, 1'b0));
      for (int bi = 0; bi < n; bi++) begin
         for (int j = 0; j < p; j++) begin
            if (bi != 0 || j != 0) @(negedge clk);
            bus.RX_IN = b[bi] ^ (bi == gbit && j == p / 2 + 1);
            if (chg && bi == 4 && j == 0)
               bus.Prescale = (p == 8) ? PW'(16) : PW'(8);
            if (chg && bi == n - 1 && j == 0) bus.Prescale = PW'(p);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int e0;
      bus.RX_IN    = 1'b1;
      bus.Prescale = PW'(8);
      bus.PAR_EN   = 1'b0;
      bus.PAR_TYP  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", 32'({bus.sampled_bit, bus.deser_en,
          bus.data_valid, bus.par_err, bus.stp_err}), 32'b10000);
      rst_n = 1'b1;
      idle(4);

      // 0xA5, P=8, no parity
      send(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, -1);
      idle(6);
      chk("t1_deser", 32'(deser), 32'hA5);
      chk("t1_sb_empty", sbq.size(), 0);

      // 0x3C, P=16, even parity: good then bad parity bit
      bus.Prescale = PW'(16);
      bus.PAR_EN   = 1'b1;
      send(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, -1);
      idle(6);
      send(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, -1);
      idle(6);
      chk("t2_sb_empty", sbq.size(), 0);

      // 0x00, P=32, stop bit 0; next frame starts right after STOP
      bus.Prescale = PW'(32);
      bus.PAR_EN   = 1'b0;
      send(8'h00, 32, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, -1);
      idle(1);
      send(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, -1);
      idle(6);
      chk("t3_deser", 32'(deser), 32'h81);
      chk("t3_sb_empty", sbq.size(), 0);

      // 3-cycle start glitch at P=16, then data-bit glitch
      bus.Prescale = PW'(16);
      repeat (3) begin
         @(negedge clk);
         bus.RX_IN = 1'b0;
      end
      idle(14);
      chk("t4_glitch_sb", 32'(bus.sampled_bit), 32'd1);
      send(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 3);
      idle(6);
      chk("t4_deser", 32'(deser), 32'h3C);
      chk("t4_sb_empty", sbq.size(), 0);

      // back-to-back 0x55, 0xAA at P=8, Prescale disturbed in frame 1
      bus.Prescale = PW'(8);
      send(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, -1);
      chk("t5_mid_deser", 32'(deser), 32'h55);
      send(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, -1);
      idle(6);
      chk("t5_deser", 32'(deser), 32'hAA);
      chk("t5_sb_empty", sbq.size(), 0);

      // reset during data bit 3 of a 0x0F frame
      bus.PAR_EN  = 1'b1;
      bus.PAR_TYP = 1'b1;
      @(negedge clk);
      e0 = cyc + 1;
      for (int i = 0; i < 3; i++)
         sbq.push_back(mk(DE, e0 + (i + 2) * 8 - 1, 1'b1));
      bus.RX_IN = 1'b0;
      repeat (7) @(negedge clk);
      for (int k = 0; k < 27; k++) begin
         @(negedge clk);
         bus.RX_IN = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_reset_outs", 32'({bus.sampled_bit, bus.deser_en,
          bus.data_valid, bus.par_err, bus.stp_err}), 32'b10000);
      @(negedge clk);
      rst_n = 1'b1;
      idle(20);
      chk("t6_sb_empty", sbq.size(), 0);
      send(8'h96, 8, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, -1);
      idle(6);
      chk("t6_deser", 32'(deser), 32'h96);
      chk("t6_final_empty", sbq.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
